// File: rtl/fdt_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fdt_checker_if                                                |
// | Purpose  : Signal bundle between the PCD pause / load-modulation         |
// |            front end and the frame-delay-time checker.                   |
// | Ports    : master -> drives pause_n_synchronised, last_tx_bit,           |
// |                     mod_detected; observes the result signals.          |
// |            slave  -> the checker side (receives pause/mod, drives busy,  |
// |                     meas_valid, meas_ticks, meas_ok/early/late,          |
// |                     meas_timeout).                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface fdt_checker_if #(
  parameter int COUNT_WIDTH = 12
);
  logic                   pause_n_synchronised;
  logic                   last_tx_bit;
  logic                   mod_detected;
  logic                   busy;
  logic                   meas_valid;
  logic [COUNT_WIDTH-1:0] meas_ticks;
  logic                   meas_ok;
  logic                   meas_early;
  logic                   meas_late;
  logic                   meas_timeout;

  modport master (
    output pause_n_synchronised, last_tx_bit, mod_detected,
    input  busy, meas_valid, meas_ticks, meas_ok, meas_early, meas_late,
           meas_timeout
  );

  modport slave (
    input  pause_n_synchronised, last_tx_bit, mod_detected,
    output busy, meas_valid, meas_ticks, meas_ok, meas_early, meas_late,
           meas_timeout
  );
endinterface
`default_nettype wire

// File: rtl/fdt_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fdt_checker                                                   |
// | Purpose  : Reader-side frame-delay-time checker. Counts clock ticks from |
// |            the rising edge of the last PCD pause to the first rising     |
// |            edge of PICC load modulation and classifies the result        |
// |            against the FDT required for the last transmitted bit.        |
// | Ports    : clk, rst_n (async, active low)                                |
// |            bus (fdt_checker_if.slave): pause/modulation/last-bit in,     |
// |            busy, meas_valid, meas_ticks, meas_ok/early/late,             |
// |            meas_timeout out.                                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fdt_checker #(
  parameter int COUNT_WIDTH    = 12,
  parameter int FDT_LAST_BIT_0 = 1172,
  parameter int FDT_LAST_BIT_1 = 1236,
  parameter int TOLERANCE      = 0,
  parameter int TIMING_ADJUST  = 0,
  parameter int TIMEOUT_TICKS  = 4000
) (
  input wire           clk,
  input wire           rst_n,
  fdt_checker_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] c_adjust  = COUNT_WIDTH'(TIMING_ADJUST);
  localparam logic [COUNT_WIDTH-1:0] c_timeout = COUNT_WIDTH'(TIMEOUT_TICKS);
  localparam logic [COUNT_WIDTH-1:0] c_one     = COUNT_WIDTH'(1);

  // Window limits are kept signed and wide so that a tolerance larger than
  // the expected FDT cannot wrap the lower bound.
  localparam logic signed [33:0] c_lo_0 = 34'(FDT_LAST_BIT_0 - TOLERANCE);
  localparam logic signed [33:0] c_hi_0 = 34'(FDT_LAST_BIT_0 + TOLERANCE);
  localparam logic signed [33:0] c_lo_1 = 34'(FDT_LAST_BIT_1 - TOLERANCE);
  localparam logic signed [33:0] c_hi_1 = 34'(FDT_LAST_BIT_1 + TOLERANCE);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic                   r_pause_d;
  logic                   r_mod_d;
  logic                   w_pause_rise;
  logic                   w_mod_rise;

  logic                   r_valid;
  logic                   w_valid_next;
  logic                   r_timeout;
  logic                   w_timeout_next;
  logic [COUNT_WIDTH-1:0] r_ticks;
  logic [COUNT_WIDTH-1:0] w_ticks_next;
  logic                   r_ok;
  logic                   w_ok_next;
  logic                   r_early;
  logic                   w_early_next;
  logic                   r_late;
  logic                   w_late_next;

  logic [COUNT_WIDTH-1:0] w_ticks_meas;
  logic signed [33:0]     w_ticks_ext;
  logic signed [33:0]     w_lo;
  logic signed [33:0]     w_hi;

  assign w_pause_rise = bus.pause_n_synchronised & ~r_pause_d;
  assign w_mod_rise   = bus.mod_detected & ~r_mod_d;

  // Latency compensation is applied before classification so the window
  // comparison sees the same value that is reported.
  assign w_ticks_meas = r_count + c_adjust;
  assign w_ticks_ext  = 34'(w_ticks_meas);
  assign w_lo         = bus.last_tx_bit ? c_lo_1 : c_lo_0;
  assign w_hi         = bus.last_tx_bit ? c_hi_1 : c_hi_0;

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_valid_next   = 1'b0;
    w_timeout_next = 1'b0;
    w_ticks_next   = r_ticks;
    w_ok_next      = r_ok;
    w_early_next   = r_early;
    w_late_next    = r_late;

    if (w_pause_rise) begin
      // A new pause always restarts, even over a coincident modulation edge.
      w_state_next = COUNTING;
      w_count_next = c_one;
    end else begin
      case (r_state)
        IDLE: begin
          w_count_next = '0;
        end
        COUNTING: begin
          if (w_mod_rise && bus.pause_n_synchronised) begin
            w_state_next = IDLE;
            w_count_next = '0;
            w_valid_next = 1'b1;
            w_ticks_next = w_ticks_meas;
            w_early_next = (w_ticks_ext < w_lo);
            w_late_next  = (w_ticks_ext > w_hi);
            w_ok_next    = !(w_ticks_ext < w_lo) && !(w_ticks_ext > w_hi);
          end else if (r_count == c_timeout) begin
            w_state_next   = IDLE;
            w_count_next   = '0;
            w_timeout_next = 1'b1;
          end else begin
            w_count_next = r_count + c_one;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_pause_d <= 1'b1;
      r_mod_d   <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ticks   <= '0;
      r_ok      <= 1'b0;
      r_early   <= 1'b0;
      r_late    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_pause_d <= bus.pause_n_synchronised;
      r_mod_d   <= bus.mod_detected;
      r_valid   <= w_valid_next;
      r_timeout <= w_timeout_next;
      r_ticks   <= w_ticks_next;
      r_ok      <= w_ok_next;
      r_early   <= w_early_next;
      r_late    <= w_late_next;
    end
  end

  assign bus.busy         = (r_state == COUNTING);
  assign bus.meas_valid   = r_valid;
  assign bus.meas_timeout = r_timeout;
  assign bus.meas_ticks   = r_ticks;
  assign bus.meas_ok      = r_ok;
  assign bus.meas_early   = r_early;
  assign bus.meas_late    = r_late;

endmodule
`default_nettype wire

// File: tb/tb_fdt_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fdt_checker                                                |
// | Purpose  : Self-checking bench for fdt_checker. Three instances share   |
// |            one stimulus: default parameters, TIMING_ADJUST = 4, and a    |
// |            small configuration used for randomized scoreboard runs.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fdt_checker;

  localparam int W     = 12;
  localparam int TO    = 4000;
  localparam int SW    = 7;
  localparam int SF0   = 40;
  localparam int SF1   = 46;
  localparam int STOL  = 2;
  localparam int SADJ  = 3;
  localparam int STO   = 100;
  localparam int NRUNS = 250;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic pause_n  = 1'b1;
  logic last_bit = 1'b0;
  logic mod      = 1'b0;
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fdt_checker_if #(.COUNT_WIDTH(W))  if_a ();
  fdt_checker_if #(.COUNT_WIDTH(W))  if_b ();
  fdt_checker_if #(.COUNT_WIDTH(SW)) if_s ();

  assign if_a.pause_n_synchronised = pause_n;
  assign if_a.last_tx_bit          = last_bit;
  assign if_a.mod_detected         = mod;
  assign if_b.pause_n_synchronised = pause_n;
  assign if_b.last_tx_bit          = last_bit;
  assign if_b.mod_detected         = mod;
  assign if_s.pause_n_synchronised = pause_n;
  assign if_s.last_tx_bit          = last_bit;
  assign if_s.mod_detected         = mod;

  fdt_checker #(.COUNT_WIDTH(W)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fdt_checker #(.COUNT_WIDTH(W), .TIMING_ADJUST(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  fdt_checker #(.COUNT_WIDTH(SW), .FDT_LAST_BIT_0(SF0), .FDT_LAST_BIT_1(SF1),
                .TOLERANCE(STOL), .TIMING_ADJUST(SADJ), .TIMEOUT_TICKS(STO))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

  // Pulse monitors: running totals and last-seen cycle stamps.
  int a_nv = 0, a_nt = 0, a_vcyc = -1, a_tcyc = -1, b_nv = 0, both_hi = 0;
  always @(negedge clk) begin
    if (if_a.meas_valid)   begin a_nv <= a_nv + 1; a_vcyc <= cyc; end
    if (if_a.meas_timeout) begin a_nt <= a_nt + 1; a_tcyc <= cyc; end
    if (if_b.meas_valid)   b_nv <= b_nv + 1;
    if ((if_a.meas_valid && if_a.meas_timeout) || (if_s.meas_valid && if_s.meas_timeout))
      both_hi <= both_hi + 1;
  end

  typedef struct {
    int c;
    bit to;
    int ticks;
    bit ok;
    bit early;
    bit late;
  } ev_t;

  ev_t exp_q[$];
  ev_t act_q[$];
  bit  sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on && if_s.meas_valid)
      act_q.push_back('{c: cyc, to: 1'b0, ticks: int'(if_s.meas_ticks),
                        ok: if_s.meas_ok, early: if_s.meas_early, late: if_s.meas_late});
    if (sb_on && if_s.meas_timeout)
      act_q.push_back('{c: cyc, to: 1'b1, ticks: 0, ok: 1'b0, early: 1'b0, late: 1'b0});
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required completion", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 20000) begin @(posedge clk); #1; guard++; end
  endtask

  // Drives a pause of low_len cycles; p is the edge after which it rose.
  task automatic do_pause(input int low_len, output int p);
    pause_n = 1'b0;
    step(low_len);
    pause_n = 1'b1;
    p = cyc;
  endtask

  // Reference model: outcome of a measurement on the small instance whose
  // last pause rose after edge p and whose modulation rose d edges later.
  function automatic ev_t ref_result(input int p, input int d, input bit lb);
    ev_t e;
    int  t, req;
    if (d > STO) begin
      e = '{c: p + STO + 1, to: 1'b1, ticks: 0, ok: 1'b0, early: 1'b0, late: 1'b0};
    end else begin
      t   = (d + SADJ) % (1 << SW);
      req = lb ? SF1 : SF0;
      e.c     = p + d + 1;
      e.to    = 1'b0;
      e.ticks = t;
      e.early = (t < req - STOL);
      e.late  = (t > req + STOL);
      e.ok    = (t >= req - STOL) && (t <= req + STOL);
    end
    return e;
  endfunction

  typedef struct {
    bit lb;
    int d;      // modulation delay after the pause rise; -1 = none
    bit v;      // result expected (otherwise timeout)
    int ticks;
    bit ok;
    bit early;
    bit late;
  } vec_t;

  vec_t vt[9];

  initial begin
    int  p, p0, nv0, nt0, bnv0, lim, held_ticks;
    bit  [2:0] held_flags;

    vt[0] = '{lb: 1'b0, d: 1,    v: 1'b1, ticks: 1,    ok: 1'b0, early: 1'b1, late: 1'b0};
    vt[1] = '{lb: 1'b0, d: 1172, v: 1'b1, ticks: 1172, ok: 1'b1, early: 1'b0, late: 1'b0};
    vt[2] = '{lb: 1'b1, d: 1236, v: 1'b1, ticks: 1236, ok: 1'b1, early: 1'b0, late: 1'b0};
    vt[3] = '{lb: 1'b1, d: 1235, v: 1'b1, ticks: 1235, ok: 1'b0, early: 1'b1, late: 1'b0};
    vt[4] = '{lb: 1'b1, d: 1237, v: 1'b1, ticks: 1237, ok: 1'b0, early: 1'b0, late: 1'b1};
    vt[5] = '{lb: 1'b0, d: 1171, v: 1'b1, ticks: 1171, ok: 1'b0, early: 1'b1, late: 1'b0};
    vt[6] = '{lb: 1'b0, d: 1173, v: 1'b1, ticks: 1173, ok: 1'b0, early: 1'b0, late: 1'b1};
    vt[7] = '{lb: 1'b1, d: 4000, v: 1'b1, ticks: 4000, ok: 1'b0, early: 1'b0, late: 1'b1};
    vt[8] = '{lb: 1'b0, d: -1,   v: 1'b0, ticks: 0,    ok: 1'b0, early: 1'b0, late: 1'b0};

    // Reset state
    step(3);
    chk("reset_outputs", {if_a.busy, if_a.meas_valid, if_a.meas_timeout, if_a.meas_ok,
                          if_a.meas_early, if_a.meas_late, if_a.meas_ticks}, 64'd0);
    rst_n = 1'b1;
    step(3);
    chk("idle_busy", if_a.busy, 1'b0);

    // Table-driven single measurements
    held_ticks = 0;
    held_flags = 3'b000;
    for (int i = 0; i < 9; i++) begin
      nv0 = a_nv; nt0 = a_nt;
      last_bit = vt[i].lb;
      do_pause(2, p);
      lim = (vt[i].d < 0 || vt[i].d > TO) ? TO : vt[i].d;
      if (vt[i].d >= 0) begin
        wait_until(p + vt[i].d);
        mod = 1'b1;
      end
      if (i == 1) chk("busy_counting", if_a.busy, 1'b1);
      wait_until(p + lim + 4);
      mod = 1'b0;
      step(2);
      if (vt[i].v) begin
        chk($sformatf("vec%0d_valid_count", i), a_nv - nv0, 1);
        chk($sformatf("vec%0d_valid_cycle", i), a_vcyc, p + vt[i].d + 1);
        chk($sformatf("vec%0d_ticks", i), if_a.meas_ticks, vt[i].ticks);
        chk($sformatf("vec%0d_flags", i), {if_a.meas_ok, if_a.meas_early, if_a.meas_late},
            {vt[i].ok, vt[i].early, vt[i].late});
        chk($sformatf("vec%0d_no_timeout", i), a_nt - nt0, 0);
        held_ticks = vt[i].ticks;
        held_flags = {vt[i].ok, vt[i].early, vt[i].late};
      end else begin
        chk($sformatf("vec%0d_timeout_count", i), a_nt - nt0, 1);
        chk($sformatf("vec%0d_timeout_cycle", i), a_tcyc, p + TO + 1);
        chk($sformatf("vec%0d_no_valid", i), a_nv - nv0, 0);
        chk($sformatf("vec%0d_ticks_held", i), if_a.meas_ticks, held_ticks);
        chk($sformatf("vec%0d_flags_held", i), {if_a.meas_ok, if_a.meas_early, if_a.meas_late},
            held_flags);
      end
    end

    // Three pauses 200 ticks apart: only the last one counts
    nv0 = a_nv; nt0 = a_nt;
    last_bit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_until(p + 198);
      do_pause(2, p);
    end
    wait_until(p + 1172); mod = 1'b1;
    wait_until(p + 1176); mod = 1'b0;
    step(2);
    chk("multi_pause_count", (a_nv - nv0) + (a_nt - nt0), 1);
    chk("multi_pause_cycle", a_vcyc, p + 1173);
    chk("multi_pause_ticks", if_a.meas_ticks, 1172);
    chk("multi_pause_ok", {if_a.meas_ok, if_a.meas_early, if_a.meas_late}, 3'b100);

    // Modulation while the pause is low is ignored
    nv0 = a_nv;
    last_bit = 1'b1;
    do_pause(2, p0);
    wait_until(p0 + 100); pause_n = 1'b0;
    wait_until(p0 + 103); mod = 1'b1;
    wait_until(p0 + 106); mod = 1'b0;
    wait_until(p0 + 110); pause_n = 1'b1; p = cyc;
    chk("mod_in_pause_ignored", a_nv - nv0, 0);
    wait_until(p + 1236); mod = 1'b1;
    wait_until(p + 1240); mod = 1'b0;
    step(2);
    chk("after_pause_mod_count", a_nv - nv0, 1);
    chk("after_pause_mod_ticks", if_a.meas_ticks, 1236);

    // Modulation in IDLE is ignored
    nv0 = a_nv; nt0 = a_nt;
    mod = 1'b1; step(4); mod = 1'b0; step(20);
    chk("mod_idle_ignored", (a_nv - nv0) + (a_nt - nt0), 0);

    // Modulation already high at the pause rise
    nv0 = a_nv;
    last_bit = 1'b0;
    mod = 1'b1; step(2);
    do_pause(2, p);
    wait_until(p + 50);
    chk("mod_high_at_pause", a_nv - nv0, 0);
    mod = 1'b0;
    wait_until(p + 1172); mod = 1'b1;
    wait_until(p + 1176); mod = 1'b0;
    step(2);
    chk("mod_refall_count", a_nv - nv0, 1);
    chk("mod_refall_ticks", if_a.meas_ticks, 1172);

    // Simultaneous pause rise and modulation rise: restart, no result
    nv0 = a_nv;
    do_pause(2, p0);
    wait_until(p0 + 300);
    pause_n = 1'b0; step(2);
    pause_n = 1'b1; mod = 1'b1; p = cyc;
    step(10);
    chk("simultaneous_no_result", a_nv - nv0, 0);
    mod = 1'b0;
    wait_until(p + 1172); mod = 1'b1;
    wait_until(p + 1176); mod = 1'b0;
    step(2);
    chk("simultaneous_then_result", a_nv - nv0, 1);
    chk("simultaneous_cycle", a_vcyc, p + 1173);
    chk("simultaneous_ticks", if_a.meas_ticks, 1172);

    // Latency compensation on the adjusted instance
    bnv0 = a_nv; nv0 = b_nv;
    do_pause(2, p);
    wait_until(p + 1168); mod = 1'b1;
    wait_until(p + 1172); mod = 1'b0;
    step(2);
    chk("adj_valid", b_nv - nv0, 1);
    chk("adj_ticks", if_b.meas_ticks, 1172);
    chk("adj_ok", {if_b.meas_ok, if_b.meas_early, if_b.meas_late}, 3'b100);
    chk("unadj_ticks", if_a.meas_ticks, 1168);
    chk("unadj_early", {if_a.meas_ok, if_a.meas_early, if_a.meas_late}, 3'b010);

    // Reset mid-count
    nv0 = a_nv; nt0 = a_nt;
    do_pause(2, p);
    wait_until(p + 600);
    rst_n = 1'b0; #1;
    chk("reset_mid_outputs", {if_a.busy, if_a.meas_valid, if_a.meas_timeout, if_a.meas_ok,
                              if_a.meas_early, if_a.meas_late, if_a.meas_ticks}, 64'd0);
    step(3);
    rst_n = 1'b1;
    wait_until(p + 1172); mod = 1'b1;
    wait_until(p + 1176); mod = 1'b0;
    step(2);
    chk("reset_mid_no_pulse", (a_nv - nv0) + (a_nt - nt0), 0);
    chk("reset_mid_after", {if_a.busy, if_a.meas_ok, if_a.meas_early, if_a.meas_late,
                            if_a.meas_ticks}, 64'd0);

    // Randomized regression on the small instance
    step(STO + 10);
    sb_on = 1'b1;
    for (int r = 0; r < NRUNS; r++) begin
      int n, d;
      bit lb;
      n  = int'($urandom_range(1, 5));
      lb = 1'($urandom_range(0, 1));
      last_bit = lb;
      for (int k = 0; k < n; k++) begin
        do_pause(int'($urandom_range(1, 3)), p);
        if (k < n - 1) step(int'($urandom_range(3, 40)));
      end
      d = int'($urandom_range(1, 115));
      wait_until(p + d);
      mod = 1'b1;
      exp_q.push_back(ref_result(p, d, lb));
      wait_until(p + d + 3);
      mod = 1'b0;
      step(int'($urandom_range(1, 4)));
    end
    step(3);
    sb_on = 1'b0;
    chk("rnd_event_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk($sformatf("rnd%0d_when", i), act_q[i].c, exp_q[i].c);
      chk($sformatf("rnd%0d_result", i),
          {act_q[i].to, act_q[i].ticks, act_q[i].ok, act_q[i].early, act_q[i].late},
          {exp_q[i].to, exp_q[i].ticks, exp_q[i].ok, exp_q[i].early, exp_q[i].late});
    end

    chk("valid_timeout_exclusive", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
